// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback,
// with a memory-ready handshake, an iterative FPU start/done handshake with timeout, and a sticky trap.
module mips_mc_ctrl #(
   parameter int MEM_WAIT    = 1,
   parameter int FPU_EN      = 1,
   parameter int FPU_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       fpu_done,
   output logic       pcwrite,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluop,
   output logic [1:0] pcsrc,
   output logic       fpu_start,
   output logic [1:0] fpu_op,
   output logic       fp_regwrite,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH  = 4'd8,  S_IEXE   = 4'd9,  S_IWB     = 4'd10, S_JUMP   = 4'd11,
      S_FPSTART = 4'd12, S_FPWAIT = 4'd13, S_FPWB    = 4'd14, S_TRAP   = 4'd15
   } state_t;

   localparam int CW = (FPU_TIMEOUT > 0) ? $clog2(FPU_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((FPU_TIMEOUT > 0) ? FPU_TIMEOUT - 1 : 0);

   state_t        st;
   logic [CW-1:0] cnt;
   logic          rdy;

   assign rdy   = (MEM_WAIT != 0) ? mem_ready : 1'b1;
   assign state = st;

   // The timeout counter only advances while waiting on the FPU; every other path clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st  <= S_FETCH;
         cnt <= '0;
      end else begin
         cnt <= '0;
         case (st)
            S_FETCH:  if (rdy) st <= S_DECODE;
            S_DECODE: begin
               case (op)
                  6'b100011, 6'b101011:         st <= S_MEMADR;
                  6'b000000:                    st <= S_RTEXE;
                  6'b000100, 6'b000101:         st <= S_BRANCH;
                  6'b001000, 6'b001101,
                  6'b001100:                    st <= S_IEXE;
                  6'b000010:                    st <= S_JUMP;
                  6'b010001: st <= (FPU_EN != 0 && funct[5:2] == 4'd0) ? S_FPSTART : S_TRAP;
                  default:                      st <= S_TRAP;
               endcase
            end
            S_MEMADR:  st <= op[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (rdy) st <= S_MEMWB;
            S_MEMWR:   if (rdy) st <= S_FETCH;
            S_RTEXE:   st <= S_ALUWB;
            S_IEXE:    st <= S_IWB;
            S_FPSTART: st <= S_FPWAIT;
            S_FPWAIT: begin
               // fpu_done takes priority over a simultaneous timeout expiry
               if (fpu_done)
                  st <= S_FPWB;
               else if (FPU_TIMEOUT > 0 && cnt == CNT_LAST)
                  st <= S_TRAP;
               else
                  cnt <= cnt + CW'(1);
            end
            S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_FPWB: st <= S_FETCH;
            S_TRAP:    st <= S_TRAP;
         endcase
      end
   end

   always_comb begin
      pcwrite     = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = 4'b0000;
      pcsrc       = 2'b00;
      fpu_start   = 1'b0;
      fp_regwrite = 1'b0;
      illegal     = 1'b0;
      fpu_op      = funct[1:0];
      case (st)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = rdy;
            pcwrite = rdy;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            memread = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_RTEXE: begin
            alusrca = 1'b1;
            aluop   = 4'b1111;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            // op[0] distinguishes BNE from BEQ, so the taken condition inverts with it
            alusrca = 1'b1;
            aluop   = 4'b0001;
            pcsrc   = 2'b01;
            pcwrite = zero ^ op[0];
         end
         S_IEXE: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
               6'b001101: aluop = 4'b0011;
               6'b001100: aluop = 4'b0111;
               default:   aluop = 4'b0000;
            endcase
         end
         S_IWB:     regwrite = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_FPSTART: fpu_start   = 1'b1;
         S_FPWB:    fp_regwrite = 1'b1;
         S_TRAP:    illegal     = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle control pattern and stimulus, which is then replayed against the DUT.
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] op = '0, funct = '0;
   logic       zero = 1'b0, mem_ready = 1'b0, fpu_done = 1'b0;

   logic       pcwrite, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc, fpu_op;
   logic [3:0] aluop, state;
   logic       fpu_start, fp_regwrite, illegal;

   logic       n_pcw, n_iord, n_mrd, n_mwr, n_irw, n_m2r, n_rdst, n_rw, n_asa, n_fst, n_fpw, n_ill;
   logic [1:0] n_asb, n_psrc, n_fop;
   logic [3:0] n_aop, n_state;

   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   mips_mc_ctrl #(.MEM_WAIT(1), .FPU_EN(1), .FPU_TIMEOUT(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .fpu_done(fpu_done),
      .pcwrite(pcwrite), .iord(iord), .memread(memread), .memwrite(memwrite),
      .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fp_regwrite(fp_regwrite),
      .illegal(illegal), .state(state)
   );

   mips_mc_ctrl #(.MEM_WAIT(1), .FPU_EN(0), .FPU_TIMEOUT(8)) u_nofpu (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .fpu_done(fpu_done),
      .pcwrite(n_pcw), .iord(n_iord), .memread(n_mrd), .memwrite(n_mwr),
      .irwrite(n_irw), .memtoreg(n_m2r), .regdst(n_rdst), .regwrite(n_rw),
      .alusrca(n_asa), .alusrcb(n_asb), .aluop(n_aop), .pcsrc(n_psrc),
      .fpu_start(n_fst), .fpu_op(n_fop), .fp_regwrite(n_fpw),
      .illegal(n_ill), .state(n_state)
   );

   logic [21:0] obs;
   assign obs = {pcwrite, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
                 alusrca, alusrcb, aluop, pcsrc, fpu_start, fpu_op, fp_regwrite, illegal};

   localparam logic [21:0] B_ILL  = 22'd1 << 0,  B_FPW = 22'd1 << 1,  B_FST  = 22'd1 << 4;
   localparam logic [21:0] B_ASA  = 22'd1 << 13, B_RW  = 22'd1 << 14, B_RDST = 22'd1 << 15;
   localparam logic [21:0] B_M2R  = 22'd1 << 16, B_IRW = 22'd1 << 17, B_MWR  = 22'd1 << 18;
   localparam logic [21:0] B_MRD  = 22'd1 << 19, B_IORD = 22'd1 << 20, B_PCW = 22'd1 << 21;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                          BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100,
                          JMP = 6'b000010, FP = 6'b010001;

   function automatic logic [21:0] f_asb(input logic [1:0] v);  return 22'(v) << 11; endfunction
   function automatic logic [21:0] f_aop(input logic [3:0] v);  return 22'(v) << 7;  endfunction
   function automatic logic [21:0] f_psrc(input logic [1:0] v); return 22'(v) << 5;  endfunction
   function automatic logic rb(); return $urandom_range(0, 1) != 0; endfunction

   typedef struct {
      logic [3:0]  st;
      logic [21:0] o;
      logic        mr, fd, z;
   } cyc_t;

   cyc_t       q[$];
   logic [5:0] cur_op, cur_funct;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [3:0] s, input logic [21:0] o, input logic mr,
                       input logic fd, input logic z);
      cyc_t c;
      c.st = s;
      c.o  = o | (22'(cur_funct[1:0]) << 2);
      c.mr = mr;
      c.fd = fd;
      c.z  = z;
      q.push_back(c);
   endtask

   // Expand one instruction into its cycle pattern. zf < 0 picks zero randomly.
   // d >= 8 means fpu_done never comes within the 8-cycle timeout window.
   task automatic gen(input logic [5:0] i_op, input logic [5:0] i_fn, input int sf, input int sm,
                      input int d, input int zf, input int ntrap, output bit trapped);
      logic z;
      logic [3:0] ia;
      cur_op = i_op;
      cur_funct = i_fn;
      trapped = 1'b0;
      q.delete();
      repeat (sf) push(4'd0, B_MRD | f_asb(2'b01), 1'b0, rb(), rb());
      push(4'd0, B_MRD | f_asb(2'b01) | B_PCW | B_IRW, 1'b1, rb(), rb());
      push(4'd1, f_asb(2'b11), rb(), rb(), rb());
      if (i_op == LW) begin
         push(4'd2, B_ASA | f_asb(2'b10), rb(), rb(), rb());
         repeat (sm) push(4'd3, B_IORD | B_MRD, 1'b0, rb(), rb());
         push(4'd3, B_IORD | B_MRD, 1'b1, rb(), rb());
         push(4'd4, B_RW | B_M2R, rb(), rb(), rb());
      end else if (i_op == SW) begin
         push(4'd2, B_ASA | f_asb(2'b10), rb(), rb(), rb());
         repeat (sm) push(4'd5, B_IORD | B_MWR, 1'b0, rb(), rb());
         push(4'd5, B_IORD | B_MWR, 1'b1, rb(), rb());
      end else if (i_op == RT) begin
         push(4'd6, B_ASA | f_aop(4'b1111), rb(), rb(), rb());
         push(4'd7, B_RDST | B_RW, rb(), rb(), rb());
      end else if (i_op == BEQ || i_op == BNE) begin
         z = (zf < 0) ? rb() : (zf != 0);
         push(4'd8, B_ASA | f_aop(4'b0001) | f_psrc(2'b01) |
                    (((i_op == BEQ) ? z : !z) ? B_PCW : 22'd0), rb(), rb(), z);
      end else if (i_op == ADDI || i_op == ORI || i_op == ANDI) begin
         ia = (i_op == ORI) ? 4'b0011 : (i_op == ANDI) ? 4'b0111 : 4'b0000;
         push(4'd9, B_ASA | f_asb(2'b10) | f_aop(ia), rb(), rb(), rb());
         push(4'd10, B_RW, rb(), rb(), rb());
      end else if (i_op == JMP) begin
         push(4'd11, f_psrc(2'b10) | B_PCW, rb(), rb(), rb());
      end else if (i_op == FP && i_fn < 6'd4) begin
         push(4'd12, B_FST, rb(), rb(), rb());
         if (d < 8) begin
            repeat (d) push(4'd13, 22'd0, rb(), 1'b0, rb());
            push(4'd13, 22'd0, rb(), 1'b1, rb());
            push(4'd14, B_FPW, rb(), rb(), rb());
         end else begin
            repeat (8) push(4'd13, 22'd0, rb(), 1'b0, rb());
            trapped = 1'b1;
         end
      end else begin
         trapped = 1'b1;
      end
      if (trapped) repeat (ntrap) push(4'd15, B_ILL, rb(), rb(), rb());
   endtask

   // Replay up to n model cycles (n < 0: all). Starts and ends on a falling edge.
   task automatic run_n(input int n);
      int lim;
      lim = (n < 0 || n > q.size()) ? q.size() : n;
      for (int i = 0; i < lim; i++) begin
         op = cur_op;
         funct = cur_funct;
         zero = q[i].z;
         mem_ready = q[i].mr;
         fpu_done = q[i].fd;
         #1;
         chk($sformatf("state op=%b c%0d", cur_op, i), 32'(state), 32'(q[i].st));
         chk($sformatf("outs op=%b c%0d", cur_op, i), 32'(obs), 32'(q[i].o));
         @(negedge clk);
      end
   endtask

   // Asynchronous reset pulse in the low phase; released on the next falling edge.
   task automatic do_reset();
      logic [21:0] e;
      mem_ready = rb();
      fpu_done = rb();
      #2 reset_n = 1'b0;
      #1;
      e = B_MRD | f_asb(2'b01) | (22'(funct[1:0]) << 2) | (mem_ready ? (B_PCW | B_IRW) : 22'd0);
      chk("reset state", 32'(state), 32'd0);
      chk("reset outs", 32'(obs), 32'(e));
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      bit tr;
      logic [5:0] rop, rfn;
      int k;
      @(negedge clk);
      do_reset();

      // reset in the middle of a stalled store
      gen(SW, 6'd3, 0, 10, 0, -1, 0, tr);
      run_n(6);
      op = SW;
      mem_ready = 1'b0;
      #1;
      chk("memwr before reset", 32'({state, memwrite}), 32'({4'd5, 1'b1}));
      do_reset();
      chk("memwrite after reset", 32'(memwrite), 32'd0);

      gen(LW, 6'd0, 0, 0, 0, -1, 0, tr); run_n(-1);
      gen(LW, 6'd1, 3, 3, 0, -1, 0, tr); run_n(-1);
      chk("lw stalled length", 32'(q.size()), 32'd11);
      gen(BEQ, 6'd0, 0, 0, 0, 1, 0, tr); run_n(-1);
      gen(BNE, 6'd0, 0, 0, 0, 1, 0, tr); run_n(-1);
      gen(BNE, 6'd0, 0, 0, 0, 0, 0, tr); run_n(-1);
      gen(ORI, 6'd5, 0, 0, 0, -1, 0, tr); run_n(-1);
      gen(ANDI, 6'd9, 0, 0, 0, -1, 0, tr); run_n(-1);
      gen(ADDI, 6'd0, 1, 0, 0, -1, 0, tr); run_n(-1);
      gen(JMP, 6'd0, 0, 0, 0, -1, 0, tr); run_n(-1);
      gen(RT, 6'h20, 0, 0, 0, -1, 0, tr); run_n(-1);

      // FPU mul, done after 5 waiting cycles; the FPU-less instance traps on the same op
      gen(FP, 6'b000010, 0, 0, 5, -1, 0, tr); run_n(-1);
      chk("nofpu illegal", 32'(n_ill), 32'd1);
      chk("nofpu state", 32'(n_state), 32'd15);
      do_reset();

      gen(FP, 6'b000011, 0, 0, 7, -1, 0, tr); run_n(-1);
      gen(FP, 6'b000010, 0, 0, 99, -1, 5, tr); run_n(-1);
      do_reset();
      gen(6'b111111, 6'd0, 0, 0, 0, -1, 100, tr); run_n(-1);
      do_reset();
      gen(FP, 6'b000110, 0, 0, 0, -1, 3, tr); run_n(-1);
      do_reset();

      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 11);
         case (k)
            0: rop = LW;   1: rop = SW;   2: rop = RT;   3: rop = BEQ;
            4: rop = BNE;  5: rop = ADDI; 6: rop = ORI;  7: rop = ANDI;
            8: rop = JMP;  9, 10: rop = FP;
            default: rop = 6'($urandom);
         endcase
         rfn = 6'($urandom);
         if (rop == FP && $urandom_range(0, 3) != 0) rfn[5:2] = 4'd0;
         gen(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9),
             -1, 4, tr);
         run_n(-1);
         if (tr) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
